// File: rtl/apb_mem_slave_param.sv
// APB3 completer backed by an internal single-port word memory.
// Features: byte strobes, programmable wait states and PSLVERR on a bad address.
// A transfer is dropped cleanly if this slave's select bit falls during ACCESS.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   psel[NUM_SLAVES]         one-hot select; only psel[SLAVE_ID] is used here
//   penable, pwrite          APB phase and direction
//   paddr, pwdata, pstrb     byte address, write data and write byte lanes
//   prdata, pready, pslverr  registered read data and response
module apb_mem_slave_param #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned SLAVE_ID    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SLAVES-1:0] psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned AW1    = ADDR_W + 1;

  // Low address bits that must be zero for a word-aligned access (none when DATA_W=8).
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << LSB) - 1);
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_X    = AW1'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                wr_q;
  logic                err_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                sel;
  logic [ADDR_W-1:0]   word_addr;
  logic                addr_err;
  logic                unused_psel;

  assign sel         = psel[SLAVE_ID];
  assign word_addr   = paddr >> LSB;
  assign addr_err    = (|(paddr & ALIGN_MASK)) || ({1'b0, word_addr} >= DEPTH_X);
  // Other slaves' select bits are intentionally ignored.
  assign unused_psel = ^psel;

  // Transfer FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          if (sel && !penable) begin
            state   <= ACCESS;
            wr_q    <= pwrite;
            err_q   <= addr_err;
            idx_q   <= IDX_W'(word_addr);
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            cnt     <= '0;
          end
        end
        ACCESS: begin
          if (!sel) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state   <= DONE;
            pready  <= 1'b1;
            pslverr <= err_q;
            prdata  <= (!wr_q && !err_q) ? mem[idx_q] : '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // A setup phase overlapping DONE is not accepted.
          state   <= IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write commits on the edge that ends DONE; a reset in that cycle cancels it.
  always_ff @(posedge clk) begin
    if (!rst && state == DONE && wr_q && !err_q) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (strb_q[b]) begin
          mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

endmodule
